// File: rtl/id_ex_stage_if.sv
// Bundle of signals between the ID stage, the ID/EX pipeline register and the PC/IF-ID write enables.
// The master side is the ID stage (and its hazard consumers); the slave side is the ID/EX register.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
);
  logic                  Flush;
  logic [4:0]            IF_ID_RegisterRn1;
  logic [4:0]            IF_ID_RegisterRm2;
  logic [4:0]            IF_ID_RegisterRd;
  logic                  ID_UsesRn1;
  logic                  ID_UsesRm2;
  logic [DATA_WIDTH-1:0] ID_ReadData1;
  logic [DATA_WIDTH-1:0] ID_ReadData2;
  logic [DATA_WIDTH-1:0] ID_SignExtImm;
  logic [DATA_WIDTH-1:0] ID_PC;
  logic                  ID_RegWrite;
  logic                  ID_MemRead;
  logic                  ID_MemWrite;
  logic                  ID_MemToReg;
  logic                  ID_ALUSrc;
  logic                  ID_Branch;
  logic                  ID_UncondBranch;
  logic [1:0]            ID_ALUOp;

  logic [4:0]            ID_EX_RegisterRn1;
  logic [4:0]            ID_EX_RegisterRm2;
  logic [4:0]            ID_EX_RegisterRd;
  logic [DATA_WIDTH-1:0] ID_EX_ReadData1;
  logic [DATA_WIDTH-1:0] ID_EX_ReadData2;
  logic [DATA_WIDTH-1:0] ID_EX_SignExtImm;
  logic [DATA_WIDTH-1:0] ID_EX_PC;
  logic                  ID_EX_RegWrite;
  logic                  ID_EX_MemRead;
  logic                  ID_EX_MemWrite;
  logic                  ID_EX_MemToReg;
  logic                  ID_EX_ALUSrc;
  logic                  ID_EX_Branch;
  logic                  ID_EX_UncondBranch;
  logic [1:0]            ID_EX_ALUOp;
  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  Stall;
  logic [CNT_WIDTH-1:0]  StallCount;

  modport master (
    output Flush, IF_ID_RegisterRn1, IF_ID_RegisterRm2, IF_ID_RegisterRd,
           ID_UsesRn1, ID_UsesRm2, ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PC,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc,
           ID_Branch, ID_UncondBranch, ID_ALUOp,
    input  ID_EX_RegisterRn1, ID_EX_RegisterRm2, ID_EX_RegisterRd,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_PC,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc,
           ID_EX_Branch, ID_EX_UncondBranch, ID_EX_ALUOp,
           PCWrite, IF_ID_Write, Stall, StallCount
  );

  modport slave (
    input  Flush, IF_ID_RegisterRn1, IF_ID_RegisterRm2, IF_ID_RegisterRd,
           ID_UsesRn1, ID_UsesRm2, ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PC,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc,
           ID_Branch, ID_UncondBranch, ID_ALUOp,
    output ID_EX_RegisterRn1, ID_EX_RegisterRm2, ID_EX_RegisterRd,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_PC,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc,
           ID_EX_Branch, ID_EX_UncondBranch, ID_EX_ALUOp,
           PCWrite, IF_ID_Write, Stall, StallCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection: one-cycle bubble insertion,
// branch-flush squashing and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = 31,
  parameter int CNT_WIDTH  = 16
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef enum logic {RUN, BUBBLE} state_e;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic       branch;
    logic       uncondBranch;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam logic [4:0] ZeroReg = 5'(ZERO_REG);

  state_e                state_q;
  ctrl_t                 ctrl_d, ctrl_q;
  logic [4:0]            rn1_q, rm2_q, rd_q;
  logic [DATA_WIDTH-1:0] readData1_q, readData2_q, signExtImm_q, pc_q;
  logic [CNT_WIDTH-1:0]  stallCount_d, stallCount_q;
  logic                  hz;
  logic                  stall;

  // Compares the load in EX against the sources the ID instruction really reads.
  always_comb begin
    hz = 1'b0;
    if (ctrl_q.memRead && (rd_q != ZeroReg)) begin
      hz = (bus.ID_UsesRn1 && (rd_q == bus.IF_ID_RegisterRn1)) ||
           (bus.ID_UsesRm2 && (rd_q == bus.IF_ID_RegisterRm2));
    end
  end

  assign stall = hz && !bus.Flush && (state_q == RUN);

  always_comb begin
    ctrl_d = '{regWrite:     bus.ID_RegWrite,
               memRead:      bus.ID_MemRead,
               memWrite:     bus.ID_MemWrite,
               memToReg:     bus.ID_MemToReg,
               aluSrc:       bus.ID_ALUSrc,
               branch:       bus.ID_Branch,
               uncondBranch: bus.ID_UncondBranch,
               aluOp:        bus.ID_ALUOp};
    if (bus.Flush || stall) begin
      ctrl_d = '0;
    end
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != {CNT_WIDTH{1'b1}})) begin
      stallCount_d = stallCount_q + CNT_WIDTH'(1);
    end
  end

  // Flush wins over everything so a redirected fetch never inherits a pending bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN:     state_q <= (stall && !bus.Flush) ? BUBBLE : RUN;
        BUBBLE:  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      rn1_q        <= '0;
      rm2_q        <= '0;
      rd_q         <= '0;
      readData1_q  <= '0;
      readData2_q  <= '0;
      signExtImm_q <= '0;
      pc_q         <= '0;
      stallCount_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      rn1_q        <= bus.IF_ID_RegisterRn1;
      rm2_q        <= bus.IF_ID_RegisterRm2;
      rd_q         <= bus.IF_ID_RegisterRd;
      readData1_q  <= bus.ID_ReadData1;
      readData2_q  <= bus.ID_ReadData2;
      signExtImm_q <= bus.ID_SignExtImm;
      pc_q         <= bus.ID_PC;
      stallCount_q <= stallCount_d;
    end
  end

  assign bus.ID_EX_RegisterRn1  = rn1_q;
  assign bus.ID_EX_RegisterRm2  = rm2_q;
  assign bus.ID_EX_RegisterRd   = rd_q;
  assign bus.ID_EX_ReadData1    = readData1_q;
  assign bus.ID_EX_ReadData2    = readData2_q;
  assign bus.ID_EX_SignExtImm   = signExtImm_q;
  assign bus.ID_EX_PC           = pc_q;
  assign bus.ID_EX_RegWrite     = ctrl_q.regWrite;
  assign bus.ID_EX_MemRead      = ctrl_q.memRead;
  assign bus.ID_EX_MemWrite     = ctrl_q.memWrite;
  assign bus.ID_EX_MemToReg     = ctrl_q.memToReg;
  assign bus.ID_EX_ALUSrc       = ctrl_q.aluSrc;
  assign bus.ID_EX_Branch       = ctrl_q.branch;
  assign bus.ID_EX_UncondBranch = ctrl_q.uncondBranch;
  assign bus.ID_EX_ALUOp        = ctrl_q.aluOp;
  assign bus.Stall              = stall;
  assign bus.PCWrite            = !stall;
  assign bus.IF_ID_Write        = !stall;
  assign bus.StallCount         = stallCount_q;

  // A bubble is never followed by a second stall of the same instruction.
  stallOneCycle: assert property (@(posedge clk) disable iff (!rst_n) stall |=> !stall);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push expected hazard outputs and
// expected ID/EX contents into queues; a monitor pops and compares each cycle.
module tb_id_ex_stage;

  localparam int DW = 64;
  localparam int CW = 4;

  localparam logic [8:0] CtrlAdd  = 9'b1_0_0_0_0_0_0_10;
  localparam logic [8:0] CtrlLdur = 9'b1_1_0_1_1_0_0_00;
  localparam logic [8:0] CtrlNop  = 9'b0_0_0_0_0_0_0_00;

  typedef struct {
    logic [4:0]    rn, rm, rd;
    logic          usesRn, usesRm;
    logic [DW-1:0] rd1, rd2, imm, pc;
    logic [8:0]    ctrl;
  } instr_t;

  typedef struct {
    instr_t        ins;
    logic          bubble;
    logic [CW-1:0] cnt;
  } regExp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int passCount = 0;
  int totalCount = 0;
  logic [CW-1:0] expCnt = '0;
  int tag = 0;

  logic    combQ[$];
  regExp_t regQ[$];

  id_ex_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .ZERO_REG(31), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic instr_t mkInstr(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                                     input logic usesRn, input logic usesRm, input logic [8:0] ctrl,
                                     input int t);
    instr_t i;
    i.rn = rn; i.rm = rm; i.rd = rd;
    i.usesRn = usesRn; i.usesRm = usesRm;
    i.rd1 = {32'hA1A1_0000, 32'(t)};
    i.rd2 = {32'hB2B2_0000, 32'(t)};
    i.imm = {32'hC3C3_0000, 32'(t)};
    i.pc  = 64'h0000_1000 + 64'(t * 4);
    i.ctrl = ctrl;
    return i;
  endfunction

  task automatic driveInstr(input instr_t i, input logic flush);
    bus.Flush             = flush;
    bus.IF_ID_RegisterRn1 = i.rn;
    bus.IF_ID_RegisterRm2 = i.rm;
    bus.IF_ID_RegisterRd  = i.rd;
    bus.ID_UsesRn1        = i.usesRn;
    bus.ID_UsesRm2        = i.usesRm;
    bus.ID_ReadData1      = i.rd1;
    bus.ID_ReadData2      = i.rd2;
    bus.ID_SignExtImm     = i.imm;
    bus.ID_PC             = i.pc;
    {bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite, bus.ID_MemToReg, bus.ID_ALUSrc,
     bus.ID_Branch, bus.ID_UncondBranch, bus.ID_ALUOp} = i.ctrl;
  endtask

  // One ID cycle: drive at the falling edge, record the hand-computed stall and the expected ID/EX result.
  task automatic applyStimulus(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                               input logic usesRn, input logic usesRm, input logic [8:0] ctrl,
                               input logic flush, input logic expStall);
    instr_t i;
    regExp_t e;
    @(negedge clk);
    tag++;
    i = mkInstr(rn, rm, rd, usesRn, usesRm, ctrl, tag);
    driveInstr(i, flush);
    if (expStall) expCnt = (expCnt == {CW{1'b1}}) ? expCnt : expCnt + 1'b1;
    e.ins = i;
    e.bubble = expStall || flush;
    e.cnt = expCnt;
    combQ.push_back(expStall);
    regQ.push_back(e);
  endtask

  task automatic checkResetOutputs(input string tagName);
    checkOutput({tagName, ".ctrl"}, 64'({bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
                bus.ID_EX_MemToReg, bus.ID_EX_ALUSrc, bus.ID_EX_Branch, bus.ID_EX_UncondBranch,
                bus.ID_EX_ALUOp}), 64'd0);
    checkOutput({tagName, ".regs"}, 64'({bus.ID_EX_RegisterRn1, bus.ID_EX_RegisterRm2, bus.ID_EX_RegisterRd}), 64'd0);
    checkOutput({tagName, ".data"}, bus.ID_EX_ReadData1 | bus.ID_EX_ReadData2 | bus.ID_EX_SignExtImm | bus.ID_EX_PC, 64'd0);
    checkOutput({tagName, ".PCWrite"}, 64'(bus.PCWrite), 64'd1);
    checkOutput({tagName, ".IF_ID_Write"}, 64'(bus.IF_ID_Write), 64'd1);
    checkOutput({tagName, ".Stall"}, 64'(bus.Stall), 64'd0);
    checkOutput({tagName, ".StallCount"}, 64'(bus.StallCount), 64'd0);
  endtask

  // Monitor: combinational hazard outputs mid-cycle, registered contents just after the edge.
  initial begin
    logic s;
    regExp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (combQ.size() > 0) begin
        s = combQ.pop_front();
        checkOutput("Stall", 64'(bus.Stall), 64'(s));
        checkOutput("PCWrite", 64'(bus.PCWrite), 64'(!s));
        checkOutput("IF_ID_Write", 64'(bus.IF_ID_Write), 64'(!s));
      end
      @(posedge clk);
      #1;
      if (regQ.size() > 0) begin
        e = regQ.pop_front();
        checkOutput("ID_EX.ctrl", 64'({bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
                    bus.ID_EX_MemToReg, bus.ID_EX_ALUSrc, bus.ID_EX_Branch, bus.ID_EX_UncondBranch,
                    bus.ID_EX_ALUOp}), e.bubble ? 64'd0 : 64'(e.ins.ctrl));
        checkOutput("StallCount", 64'(bus.StallCount), 64'(e.cnt));
        if (!e.bubble) begin
          checkOutput("ID_EX_RegisterRn1", 64'(bus.ID_EX_RegisterRn1), 64'(e.ins.rn));
          checkOutput("ID_EX_RegisterRm2", 64'(bus.ID_EX_RegisterRm2), 64'(e.ins.rm));
          checkOutput("ID_EX_RegisterRd", 64'(bus.ID_EX_RegisterRd), 64'(e.ins.rd));
          checkOutput("ID_EX_ReadData1", bus.ID_EX_ReadData1, e.ins.rd1);
          checkOutput("ID_EX_ReadData2", bus.ID_EX_ReadData2, e.ins.rd2);
          checkOutput("ID_EX_SignExtImm", bus.ID_EX_SignExtImm, e.ins.imm);
          checkOutput("ID_EX_PC", bus.ID_EX_PC, e.ins.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to be done", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t r;
    // Reset with random inputs applied.
    repeat (3) begin
      @(negedge clk);
      r = mkInstr(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 9'($urandom), 0);
      r.rd1 = {$urandom, $urandom};
      driveInstr(r, 1'($urandom));
      #2;
      checkResetOutputs("reset");
    end
    driveInstr(mkInstr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, CtrlNop, 0), 1'b0);
    #1 rst_n = 1'b1;

    // ADD X3,X1,X2 then a load-use pair on Rn1.
    applyStimulus(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CtrlLdur, 1'b0, 1'b0);
    applyStimulus(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b1);
    applyStimulus(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);

    // Loads into XZR never stall.
    applyStimulus(5'd2, 5'd0, 5'd31, 1'b1, 1'b0, CtrlLdur, 1'b0, 1'b0);
    applyStimulus(5'd31, 5'd31, 5'd4, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);

    // Matching Rm2 field that the consumer does not read.
    applyStimulus(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CtrlLdur, 1'b0, 1'b0);
    applyStimulus(5'd9, 5'd5, 5'd10, 1'b1, 1'b0, CtrlAdd, 1'b0, 1'b0);

    // Flush overrides a live hazard.
    applyStimulus(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CtrlLdur, 1'b0, 1'b0);
    applyStimulus(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CtrlAdd, 1'b1, 1'b0);
    applyStimulus(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);

    // Load-use through Rm2.
    applyStimulus(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, CtrlLdur, 1'b0, 1'b0);
    applyStimulus(5'd3, 5'd8, 5'd9, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b1);
    applyStimulus(5'd3, 5'd8, 5'd9, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);

    // Twenty stalls drive the 4-bit counter into saturation.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(5'd1, 5'd0, 5'd10, 1'b1, 1'b0, CtrlLdur, 1'b0, 1'b0);
      applyStimulus(5'd10, 5'd2, 5'd11, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b1);
      applyStimulus(5'd10, 5'd2, 5'd11, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);
    end

    // Asynchronous reset while the bubble sits in ID/EX.
    applyStimulus(5'd1, 5'd0, 5'd12, 1'b1, 1'b0, CtrlLdur, 1'b0, 1'b0);
    applyStimulus(5'd12, 5'd2, 5'd13, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #0.5;
    checkResetOutputs("asyncReset");
    expCnt = '0;
    #0.5 rst_n = 1'b1;
    applyStimulus(5'd12, 5'd2, 5'd14, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);
    applyStimulus(5'd14, 5'd12, 5'd15, 1'b1, 1'b1, CtrlAdd, 1'b0, 1'b0);

    for (int w = 0; w < 10 && (combQ.size() > 0 || regQ.size() > 0); w++) @(posedge clk);
    #3;
    if (combQ.size() > 0 || regQ.size() > 0) begin
      totalCount++;
      $display("[TB] FAIL drain: %0d entries still pending, expected 0", combQ.size() + regQ.size());
    end
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the five-stage ARMv8 pipeline. It captures decoded operands, register specifiers and control from the ID stage, and presents `ID_EX_*` fields to the EX stage, including the forwarding unit's `ID_EX_RegisterRn1`/`ID_EX_RegisterRm2`. On a load-use dependency it stalls PC and IF/ID and inserts one bubble. On a taken-branch flush it squashes the ID/EX contents.

## Interface
- `DATA_WIDTH`, 64, width of data/PC/immediate fields
- `ZERO_REG`, 31, register number XZR; never causes a hazard
- `CNT_WIDTH`, 16, width of saturating stall counter
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `Flush` in 1: branch taken in MEM; squash the ID/EX contents.
- `IF_ID_RegisterRn1`, `IF_ID_RegisterRm2`, `IF_ID_RegisterRd` in 5 each: source and destination specifiers from IF/ID.
- `ID_UsesRn1`, `ID_UsesRm2` in 1 each: the instruction in ID actually reads that source.
- `ID_ReadData1`, `ID_ReadData2`, `ID_SignExtImm`, `ID_PC` in DATA_WIDTH each.
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemToReg`, `ID_ALUSrc`, `ID_Branch`, `ID_UncondBranch` in 1 each.
- `ID_ALUOp` in 2.
- `ID_EX_*` out: registered copy of every `ID_*`/`IF_ID_Register*` input above. `ID_UsesRn1`/`ID_UsesRm2` are not registered.
- `PCWrite` out 1: 0 freezes the PC.
- `IF_ID_Write` out 1: 0 freezes the IF/ID register.
- `Stall` out 1: a load-use bubble is being inserted this cycle.
- `StallCount` out CNT_WIDTH: number of bubbles inserted, saturating.

## Operation
- Hazard condition `hz` (combinational) is true when all of the following hold:
  - `ID_EX_MemRead`
  - `ID_EX_RegisterRd != ZERO_REG`
  - either (`ID_UsesRn1` && `ID_EX_RegisterRd == IF_ID_RegisterRn1`) or (`ID_UsesRm2` && `ID_EX_RegisterRd == IF_ID_RegisterRm2`)
- `Stall = hz && !Flush && state==RUN`.
- `PCWrite = IF_ID_Write = !Stall`.
- FSM states:
  - RUN (reset state).
  - BUBBLE: the bubble is in ID/EX and the dependent instruction is held in ID.
- FSM transitions:
  - RUN→BUBBLE when `Stall`.
  - BUBBLE→RUN unconditionally on the next edge.
  - `Flush` in any state forces the next state to RUN.
- A stall never lasts more than 1 cycle. Stall is gated off in BUBBLE; because a bubble has MemRead=0, `hz` is also false there.
- Register update on each rising edge:
  - Flush: all control bits (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, UncondBranch, ALUOp) are cleared. Data and specifier fields load normally, and are don't-care.
  - else if Stall: same as Flush, control bits cleared (bubble). Data and specifiers load.
  - else: all fields load from the ID inputs.
- Flush has priority over Stall. During Flush, `PCWrite`=`IF_ID_Write`=1, since the fetch redirect must proceed.
- `StallCount` increments by 1 on each edge where `Stall`=1. It saturates at all-ones and does not wrap.
- The module contains no forwarding logic. EX forwards from EX/MEM and MEM/WB using the registered `ID_EX_Register*` fields.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - every `ID_EX_*` output = 0
  - state = RUN
  - `StallCount` = 0
  - consequently `Stall`=0 and `PCWrite`=`IF_ID_Write`=1
- Reset asserted mid-stall returns to RUN immediately. No bubble is pending after release.
- Latency is 1 cycle from the ID inputs to the `ID_EX_*` outputs.
- `Stall`/`PCWrite`/`IF_ID_Write` are combinational in the same cycle. Paths:
  - `ID_EX_*` flops → compare → out
  - IF_ID inputs → compare → out
- Load-use sequence (cycle numbers):
  - c0: load in ID.
  - c1: load in EX, dependent instruction in ID, `Stall`=1.
  - c2: bubble in EX, the load in MEM, the dependent instruction still in ID, `Stall`=0.
  - c3: the dependent instruction is in EX. MEM/WB forwarding supplies the load data.
- Flush and hz in the same cycle: no stall, the ID/EX register is squashed, the FSM stays in RUN, and `StallCount` is unchanged.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all `ID_EX_*`=0, `PCWrite`=1, `StallCount`=0. Release, apply ADD with Rn=1, Rm=2, Rd=3 → next edge `ID_EX_RegisterRd`=3, `ID_EX_RegWrite`=1.
- Load-use: LDUR X5 in EX, ADD X6,X5,X7 in ID (UsesRn1=1) → `Stall`=1 and `PCWrite`=0 for exactly 1 cycle. Next cycle `ID_EX_MemRead`=0 and `ID_EX_RegWrite`=0 (bubble). Following cycle `ID_EX_RegisterRn1`=5. `StallCount`=1.
- No false stall:
  - LDUR into X31 with a consumer reading X31 → `Stall`=0.
  - LDUR X5 with a consumer whose Rm2 field=5 but `ID_UsesRm2`=0 → `Stall`=0.
- Flush priority: hazard present and `Flush`=1 → `Stall`=0, `PCWrite`=1, all ID/EX control=0 after the edge, `StallCount` unchanged.
- Saturation: with CNT_WIDTH=4, generate 20 load-use stalls → `StallCount` reaches 15 and stays 15.
- Async reset in BUBBLE: assert `rst_n`=0 between edges → outputs clear immediately. After release, a non-hazard instruction flows with no extra bubble.
